// File: rtl/camera_decode_pkg.sv
// Shared constants, FSM state types and the W-channel payload for the camera_decode
// AXI4-Lite register block.
package camera_decode_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [2:0] REG_CTRL0     = 3'd0;
    localparam logic [2:0] REG_CTRL1     = 3'd1;
    localparam logic [2:0] REG_CTRL2     = 3'd2;
    localparam logic [2:0] REG_CTRL3     = 3'd3;
    localparam logic [2:0] REG_FRAME_CNT = 3'd4;
    localparam logic [2:0] REG_STATUS    = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_beat_t;

endpackage

// File: rtl/camera_decode_axil_wr_hold.sv
// One-entry holding register with valid flag, used to decouple the AW and W channels.
module camera_decode_axil_wr_hold #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             held,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            held <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            held <= 1'b0;
        end else if (load) begin
            held <= 1'b1;
            q    <= d;
        end
    end

endmodule

// File: rtl/camera_decode_axil_slave.sv
// AXI4-Lite register block for camera_decode: four control registers, frame counter
// and overflow sticky status, with independent write and read FSMs.
module camera_decode_axil_slave
    import camera_decode_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned FRAME_CNT_WIDTH    = 32
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3,
    input  logic                            frame_done,
    input  logic                            overflow_err
);

    logic                       clk, rst;
    wr_state_t                  w_state_q, w_state_d;
    rd_state_t                  r_state_q, r_state_d;
    logic                       awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [DATA_W-1:0]          ctrl_q [4];
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    logic                       sticky_q;
    logic                       aw_held, w_held, aw_hs_c, w_hs_c, ar_hs_c;
    logic                       wr_en_c, hold_clr_c, sticky_clr_c;
    logic [2:0]                 aw_idx, rd_idx;
    wr_beat_t                   w_in_c, w_beat;
    logic [1:0]                 wr_resp_c, rd_resp_c;
    logic [DATA_W-1:0]          rd_mux_c;
    logic                       unused_c;

    assign clk      = s00_axi_aclk;
    assign rst      = s00_axi_areset;
    assign aw_hs_c  = s00_axi_awvalid && awready_q;
    assign w_hs_c   = s00_axi_wvalid && wready_q;
    assign ar_hs_c  = s00_axi_arvalid && arready_q;
    assign w_in_c   = '{data: s00_axi_wdata, strb: s00_axi_wstrb};
    assign rd_idx   = s00_axi_araddr[4:2];
    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    camera_decode_axil_wr_hold #(.WIDTH(3)) u_aw_hold (
        .clk(clk), .rst(rst), .load(aw_hs_c), .clear(hold_clr_c),
        .d(s00_axi_awaddr[4:2]), .held(aw_held), .q(aw_idx)
    );

    camera_decode_axil_wr_hold #(.WIDTH($bits(wr_beat_t))) u_w_hold (
        .clk(clk), .rst(rst), .load(w_hs_c), .clear(hold_clr_c),
        .d(w_in_c), .held(w_held), .q(w_beat)
    );

    always_comb begin
        wr_resp_c = (aw_idx <= REG_CTRL3 || aw_idx == REG_STATUS) ? RESP_OKAY : RESP_SLVERR;
    end

    // Write FSM: commit once both holders are full, then wait for B acceptance.
    always_comb begin
        w_state_d  = w_state_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_en_c    = 1'b0;
        hold_clr_c = 1'b0;
        case (w_state_q)
            W_IDLE: if (aw_held && w_held) begin
                wr_en_c   = 1'b1;
                bvalid_d  = 1'b1;
                bresp_d   = wr_resp_c;
                w_state_d = W_RESP;
            end
            W_RESP: if (s00_axi_bready) begin
                bvalid_d   = 1'b0;
                hold_clr_c = 1'b1;
                w_state_d  = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = !(hold_clr_c ? 1'b0 : (aw_held || aw_hs_c)) && (w_state_d == W_IDLE);
        wready_d  = !(hold_clr_c ? 1'b0 : (w_held || w_hs_c)) && (w_state_d == W_IDLE);
    end

    always_comb begin
        rd_resp_c = RESP_OKAY;
        case (rd_idx)
            REG_CTRL0:     rd_mux_c = ctrl_q[0];
            REG_CTRL1:     rd_mux_c = ctrl_q[1];
            REG_CTRL2:     rd_mux_c = ctrl_q[2];
            REG_CTRL3:     rd_mux_c = ctrl_q[3];
            REG_FRAME_CNT: rd_mux_c = DATA_W'(frame_cnt_q);
            REG_STATUS:    rd_mux_c = DATA_W'(sticky_q);
            default: begin
                rd_mux_c  = '0;
                rd_resp_c = RESP_SLVERR;
            end
        endcase
    end

    // Read FSM: capture on AR handshake, hold until R is accepted.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (ar_hs_c) begin
                rvalid_d  = 1'b1;
                rdata_d   = rd_mux_c;
                rresp_d   = rd_resp_c;
                r_state_d = R_DATA;
            end
            R_DATA: if (s00_axi_rready) begin
                rvalid_d  = 1'b0;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) ctrl_q[r] <= '0;
        end else if (wr_en_c && aw_idx <= REG_CTRL3) begin
            for (int b = 0; b < int'(STRB_W); b++)
                if (w_beat.strb[b]) ctrl_q[aw_idx[1:0]][8*b +: 8] <= w_beat.data[8*b +: 8];
        end
    end

    // Soft clear outranks counting; enable is the value before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || ctrl_q[0][1])            frame_cnt_q <= '0;
        else if (frame_done && ctrl_q[0][0]) frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
    end

    assign sticky_clr_c = wr_en_c && aw_idx == REG_STATUS && w_beat.data[0] && w_beat.strb[0];

    always_ff @(posedge clk) begin
        if (rst)               sticky_q <= 1'b0;
        else if (overflow_err) sticky_q <= 1'b1;
        else if (sticky_clr_c) sticky_q <= 1'b0;
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign ctrl_reg0       = ctrl_q[0];
    assign ctrl_reg1       = ctrl_q[1];
    assign ctrl_reg2       = ctrl_q[2];
    assign ctrl_reg3       = ctrl_q[3];

endmodule

// File: doc/camera_decode_axil_slave.md
Name: camera_decode_axil_slave

Overview:
- AXI4-Lite responder for the camera_decode IP's S00_AXI port. It is the register-side counterpart of the master VIP that drives sequential write/read bursts.
- Holds four read/write 32-bit control registers (0x00-0x0C) and two read-only status registers (0x10, 0x14).
- Exports the control registers to the OV7670 decode core and counts frame events from that core.
- Sits between the PS AXI interconnect and the camera decode datapath.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; covers offsets 0x00-0x1C.
- FRAME_CNT_WIDTH, 32, width of the frame counter in status register 0x10.

Ports:
- s00_axi_aclk  in  1  single clock for the whole block.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
- s00_axi_bresp  out  2  write response: OKAY=0, SLVERR=2.
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
- ctrl_reg0..ctrl_reg3  out  32 each  current register contents, driven to the decode core.
- frame_done  in  1  one-cycle pulse from the decode core at end of frame.
- overflow_err  in  1  one-cycle pulse from the decode core on pixel FIFO overflow.

Behaviour:
- Reset (synchronous, s00_axi_areset=1 at a clock edge):
  - all ready/valid outputs = 0; bresp = 0; rresp = 0; rdata = 0.
  - ctrl_reg0..3 = 0; frame counter = 0; error sticky = 0.
  - Any in-flight AW, W, B or R state is discarded.
- Write path, FSM W_IDLE -> W_RESP:
  - AW and W are captured independently into one-entry holding registers. awready=1 while AW is not held and FSM is in W_IDLE; wready likewise for W.
  - When both are held (arriving in the same cycle or different cycles), the register update happens on the next edge. bvalid rises on that same edge; FSM goes to W_RESP.
  - Minimum latency: AW and W both accepted at edge N -> register updated and bvalid=1 after edge N+1.
  - bvalid holds until bready is sampled high. FSM then returns to W_IDLE and both holders clear. No new AW or W is accepted while in W_RESP.
- Write decode uses awaddr[4:2]; awaddr[1:0] is ignored.
  - Indices 0-3: byte lanes with wstrb[i]=1 are updated; bresp = OKAY.
  - Index 4: the counter is not changed; bresp = SLVERR.
  - Index 5, bit 0 = 1 with wstrb[0]=1: error sticky is cleared; bresp = OKAY.
  - Indices 6-7: no effect; bresp = SLVERR.
- Read path, FSM R_IDLE -> R_DATA:
  - arready=1 in R_IDLE. On AR handshake, rdata/rresp are loaded from register values as they stand before that edge, and rvalid=1 after the edge.
  - rdata and rresp stay stable until rready is sampled high, then the FSM returns to R_IDLE.
  - Back-to-back reads are therefore 2 cycles apart minimum.
- Read map:
  - 0-3: ctrl_reg0..3.
  - 4: frame counter, zero-extended.
  - 5: {31'b0, error sticky}.
  - 6-7: rdata = 0, rresp = SLVERR.
- Write and read to the same register in one cycle: the read returns the old value; the write lands.
- Frame counter:
  - Increments on frame_done when ctrl_reg0[0] (enable) = 1.
  - Wraps from all-ones to 0.
  - A frame_done in the same cycle as a write to ctrl_reg0 uses the pre-write enable.
- Error sticky:
  - Set by overflow_err.
  - If set and clear occur in the same cycle, set wins.
- Soft clear: ctrl_reg0[1] = 1 clears the frame counter every cycle it is held. The bit is not self-clearing.

Decomposition:
- Package camera_decode_pkg holds:
  - register index constants: REG_CTRL0..3 = 0..3, REG_FRAME_CNT = 4, REG_STATUS = 5.
  - response constants RESP_OKAY and RESP_SLVERR.
  - enums for the write and read FSM states.
- One natural sub-module: camera_decode_axil_wr_hold, the one-entry AW/W holding register with valid flag. It is instantiated twice.

Test Plan:
- Sequential write/read: write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> each read returns the written value with rresp=0.
- Decoupled channels: W presented 3 cycles before AW, data 0xDEADBEEF to 0x04 -> wready drops after the W handshake; bvalid follows AW acceptance by 1 cycle; reg1 = 0xDEADBEEF.
- Strobes and backpressure:
  - reg2 preloaded with 0x11223344; write 0xAABBCCDD with wstrb=0b0101 -> reg2 = 0x11BB33DD.
  - Hold bready=0 for 5 cycles -> bvalid stays 1, and no new awready during the stall.
- Status and errors:
  - With reg0 = 1, pulse frame_done 3 times -> read 0x10 returns 3.
  - Write to 0x10 -> bresp=2 and the count is unchanged.
  - Read 0x18 -> rdata=0, rresp=2.
- Reset mid-transaction: assert s00_axi_areset while bvalid=1 and rvalid=1 -> next cycle all valid/ready = 0 and registers = 0; a subsequent write/read completes normally.
